// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant of up to two result writes per cycle onto two registered ports.
// Optional statistics counters are enabled with `define WB_ARB_STATS_EN.
module wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int UID_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_all,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [3:0]          req_waddr [NUM_REQ],
  input  logic [15:0]         req_data  [NUM_REQ],
  input  logic [UID_BITS-1:0] req_uid   [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_ready,
  output logic [1:0]          wb_valid,
`ifdef WB_ARB_STATS_EN
  output logic [15:0]         stall_cnt,
  output logic [15:0]         wb_cnt,
`endif
  output logic [3:0]          wb_waddr  [2],
  output logic [15:0]         wb_data   [2],
  output logic [UID_BITS-1:0] wb_uid    [2]
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic [1:0]       port_use;
  logic [PTR_W-1:0] port_src [2];
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;
  logic             grant_on;

  assign grant_on = !rst && !flush_all && (state == ST_RUN);

  // Scan from rr_ptr; waddr 0 writes are acknowledged without taking a port.
  always_comb begin
    req_ready   = '0;
    port_use    = '0;
    port_src[0] = '0;
    port_src[1] = '0;
    rr_ptr_nxt  = rr_ptr;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      scan_idx = scan_sum[PTR_W-1:0];
      if (grant_on && req_valid[scan_idx]) begin
        if (req_waddr[scan_idx] == 4'd0) begin
          req_ready[scan_idx] = 1'b1;
        end else if (!port_use[0]) begin
          port_use[0]         = 1'b1;
          port_src[0]         = scan_idx;
          req_ready[scan_idx] = 1'b1;
          rr_ptr_nxt = (scan_idx == PTR_W'(NUM_REQ-1)) ? '0 : scan_idx + 1'b1;
        end else if (!port_use[1] && (req_waddr[scan_idx] != req_waddr[port_src[0]])) begin
          port_use[1]         = 1'b1;
          port_src[1]         = scan_idx;
          req_ready[scan_idx] = 1'b1;
          rr_ptr_nxt = (scan_idx == PTR_W'(NUM_REQ-1)) ? '0 : scan_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      rr_ptr   <= '0;
      wb_valid <= '0;
      for (int p = 0; p < 2; p++) begin
        wb_waddr[p] <= '0;
        wb_data[p]  <= '0;
        wb_uid[p]   <= '0;
      end
    end else begin
      // FLUSH lasts one cycle beyond the last cycle flush_all is seen high.
      state    <= flush_all ? ST_FLUSH : ST_RUN;
      rr_ptr   <= rr_ptr_nxt;
      wb_valid <= port_use;
      for (int p = 0; p < 2; p++) begin
        if (port_use[p]) begin
          wb_waddr[p] <= req_waddr[port_src[p]];
          wb_data[p]  <= req_data[port_src[p]];
          wb_uid[p]   <= req_uid[port_src[p]];
        end
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [16:0] wb_sum;
  assign wb_sum = {1'b0, wb_cnt} + 17'(wb_valid[0]) + 17'(wb_valid[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      wb_cnt    <= '0;
    end else begin
      if (|(req_valid & ~req_ready) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      wb_cnt <= wb_sum[16] ? 16'hFFFF : wb_sum[15:0];
    end
  end
`endif

endmodule
